// File: rtl/demux_pkg.sv
// Shared types and defaults for the two-way slot router.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 8;

    // Occupancy of a one-entry holding slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with a completed-transfer counter.
// Latency: a word loaded at edge N is presented (out_valid=1) right after edge N.
// Backpressure: holds its word while out_ready=0; the parent may only load when empty or draining.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   load, load_data       write strobe and word from the router (already qualified by in_ready)
//   out_valid, out_ready  downstream handshake
//   out_data              held word, stable while full and not drained
//   cnt                   number of completed downstream transfers, wraps
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt
);

    slot_state_t state, state_nxt;
    logic        drain;

    assign out_valid = (state == SLOT_FULL);
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load)           state_nxt = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
            default:                        state_nxt = SLOT_EMPTY;
        endcase
    end

    // The router only loads an empty or draining slot, so overwriting here
    // never destroys a word that has not been handed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_slot_router.sv
// Routes each upstream word to one of two one-entry output slots chosen by sel.
// Latency: one cycle from input acceptance to out*_valid.
// Backpressure: in_ready drops only when the selected slot is full and not draining; the other slot never blocks it.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   in_valid, in_ready, data_in, sel  upstream handshake, word and destination
//   out0_* / out1_*                   per-output valid/ready/data
//   cnt0 / cnt1                       completed transfers per output
module demux_slot_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic slot0_free;
    logic slot1_free;
    logic accept;
    logic load0;
    logic load1;

    // A slot can take a word when empty, or when its current word leaves
    // on this same edge. in_valid is deliberately not part of this term.
    assign slot0_free = ~out0_valid | out0_ready;
    assign slot1_free = ~out1_valid | out1_ready;
    assign in_ready   = sel ? slot1_free : slot0_free;

    assign accept = in_valid & in_ready;
    assign load0  = accept & ~sel;
    assign load1  = accept &  sel;

    demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (data_in),
        .out_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .cnt       (cnt0)
    );

    demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (data_in),
        .out_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux_slot_router.sv
// Randomised and directed bench for demux_slot_router with a queue scoreboard.
// Latency: expects each accepted word on its output one cycle later, in order.
// Backpressure: drives random and stalled out*_ready patterns.
module tb_demux_slot_router;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              sel;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    demux_slot_router #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .sel        (sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words accepted but not yet delivered, per output,
    // plus the number of deliveries modulo 2^CNT_W.
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int unsigned       del0;
    int unsigned       del1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("out0_valid", out0_valid, q0.size() != 0);
            check("out1_valid", out1_valid, q1.size() != 0);
            check("cnt0", cnt0, del0 % (1 << CNT_W));
            check("cnt1", cnt1, del1 % (1 << CNT_W));
            if (q0.size() != 0 && out0_ready) begin
                check("out0_data", out0_data, q0.pop_front());
                del0++;
            end
            if (q1.size() != 0 && out1_ready) begin
                check("out1_data", out1_data, q1.pop_front());
                del1++;
            end
        end
    end

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic cycle(input logic v, input logic s, input logic [DATA_W-1:0] d,
                         input logic r0, input logic r1);
        logic exp_rdy;
        in_valid   = v;
        sel        = s;
        data_in    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        exp_rdy = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (v && exp_rdy) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
    endtask

    task automatic check_zero_outputs();
        check("rst out0_valid", out0_valid, 0);
        check("rst out1_valid", out1_valid, 0);
        check("rst out0_data", out0_data, 0);
        check("rst out1_data", out1_data, 0);
        check("rst cnt0", cnt0, 0);
        check("rst cnt1", cnt1, 0);
    endtask

    // Asserts reset away from any clock edge and checks the immediate effect.
    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero_outputs();
        q0.delete();
        q1.delete();
        del0 = 0;
        del1 = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        sel        = 1'b0;
        data_in    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        del0       = 0;
        del1       = 0;
        #2;
        check_zero_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("in_ready first cycle", in_ready, 1);
        @(posedge clk);
        #1;

        // Single word to output 0, consumer ready.
        cycle(1, 0, 32'h0000_0001, 1, 0);
        cycle(0, 0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 1, 0);
        check("single word cnt0", cnt0, 1);

        // Output 1 stalled: second word must wait, output 0 must not.
        cycle(1, 1, 32'hFFFF_FFFE, 0, 0);
        cycle(1, 1, 32'h0000_0002, 0, 0);
        check("stalled slot in_ready", in_ready, 0);
        cycle(1, 1, 32'h0000_0002, 0, 0);
        cycle(1, 0, 32'h0000_0003, 1, 0);
        cycle(0, 0, 32'h0, 1, 0);
        cycle(1, 1, 32'h0000_0002, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);
        check("ordered out1 count", cnt1, 2);

        // Back-to-back streaming into output 0.
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 32'h1000_0000 + i, 1, 0);
        end
        cycle(0, 0, 32'h0, 1, 0);
        check("streaming cnt0", cnt0, 22);

        // Random traffic and backpressure.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 2, $urandom,
                  ($urandom % 3) != 0, ($urandom % 3) != 0);
        end
        cycle(0, 0, 32'h0, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);

        // Counter wrap on output 1.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1, 1, $urandom, 0, 1);
        end
        cycle(0, 0, 32'h0, 0, 1);
        cycle(0, 0, 32'h0, 0, 1);
        check("cnt1 wrap", cnt1, 0);
        check("out1 deliveries", del1, 256);

        // Reset while both slots hold a word.
        cycle(1, 0, 32'hAAAA_5555, 0, 0);
        cycle(1, 1, 32'h5555_AAAA, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("both full v0", out0_valid, 1);
        check("both full v1", out1_valid, 1);
        do_reset();
        cycle(0, 0, 32'h0, 1, 1);
        cycle(1, 1, 32'h0000_0004, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);
        cycle(0, 0, 32'h0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_slot_router.md
DEMUX_SLOT_ROUTER -- requirements
Module: demux_slot_router

Interface
REQ-001 Parameter DATA_W, default 32: width of the routed data word.
REQ-002 Parameter CNT_W, default 8: width of each per-output transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  router accepts the upstream word this cycle.
REQ-007 data_in  input  DATA_W  upstream word.
REQ-008 sel  input  1  destination: 0 -> output 0, 1 -> output 1; sampled with data_in.
REQ-009 out0_valid / out1_valid  output  1  each  holding slot occupied.
REQ-010 out0_ready / out1_ready  input  1  each  downstream consumer accepts.
REQ-011 out0_data / out1_data  output  DATA_W  each  held word.
REQ-012 cnt0 / cnt1  output  CNT_W  each  completed downstream transfers per output.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; output transfer k SHALL occur when outk_valid and outk_ready are both 1.
REQ-014 Each output SHALL own a one-entry slot with two states, EMPTY and FULL.
REQ-015 Slot transitions: EMPTY -> FULL on an input transfer with sel==k; FULL -> EMPTY on output transfer k with no simultaneous refill; FULL -> FULL on simultaneous drain and refill.
REQ-016 outk_valid SHALL be 1 exactly when slot k is FULL; outk_data SHALL be the captured word and SHALL stay stable while FULL and not drained.
REQ-017 in_ready SHALL be combinational: 1 when slot[sel] is EMPTY, or FULL with outsel_ready==1 in the same cycle; otherwise 0.
REQ-018 in_ready SHALL NOT depend on in_valid.
REQ-019 Latency: a word accepted at edge N SHALL appear on outk_data with outk_valid=1 after edge N (one cycle).
REQ-020 A FULL slot whose ready is 0 SHALL NOT block input words selected for the other slot.
REQ-021 Simultaneous drain and refill of the same slot SHALL hold outk_valid at 1 and update outk_data to the new word with no lost or duplicated word.
REQ-022 Words SHALL be delivered to each output in acceptance order; no word SHALL be dropped or duplicated.
REQ-023 cntk SHALL increment by 1 on every output transfer k and wrap from 2^CNT_W-1 to 0.
REQ-024 When in_ready is 0, data_in and sel SHALL be ignored.

Reset
REQ-025 While rst is 1, both slots SHALL be EMPTY, out0_valid=out1_valid=0, out0_data=out1_data=0, and cnt0=cnt1=0, regardless of clk.
REQ-026 Assertion of rst mid-operation SHALL discard held words; no output transfer SHALL be counted in the cycle rst deasserts.
REQ-027 in_ready SHALL be 1 on the first cycle after reset deassertion.

Structure
REQ-028 Slot state encoding (EMPTY, FULL) and default DATA_W/CNT_W SHALL live in the shared package demux_pkg.
REQ-029 The one-entry slot plus its counter SHALL be sub-module demux_slot, instantiated twice.
REQ-030 The top SHALL contain only sel decoding and in_ready generation.

Verification
REQ-031 Reset, then data_in=0x00000001, sel=0, in_valid=1 for one cycle, out0_ready=1 -> out0_valid=1 with 0x00000001 for one cycle, cnt0=1, out1_valid stays 0.
REQ-032 out1_ready=0, send 0xFFFFFFFE with sel=1, then 0x00000002 with sel=1 -> in_ready=0 on the second word; after out1_ready=1, out1 delivers 0xFFFFFFFE then 0x00000002 in order.
REQ-033 Slot 1 FULL and stalled, send 0x00000003 with sel=0 -> accepted immediately, appears on out0 next cycle.
REQ-034 Continuous in_valid with sel=0 and out0_ready=1 -> one word per cycle, out0_valid held at 1, cnt0 increments every cycle.
REQ-035 Drive 256 transfers to output 1 with CNT_W=8 -> cnt1 wraps to 0.
REQ-036 Assert rst asynchronously mid-cycle while both slots are FULL -> outputs and counters read 0 immediately and in_ready=1 after release.
